// File: rtl/display_frame_ctrl.sv
// Streams 24-bit RGB pixels into a byte-wide frame buffer in BMP bottom-up BGR order.
// Each accepted pixel becomes three byte writes on the following three cycles; pix_ready only in ACCEPT.
module display_frame_ctrl #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int ADDR_W = 18
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              DEC_DONE
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(WIDTH * 3);
    localparam logic [ADDR_W-1:0] TOP_BASE  = ADDR_W'((HEIGHT - 1) * WIDTH * 3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WR_B   = 3'd2,
        WR_G   = 3'd3,
        WR_R   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_off;
    logic [15:0]       pix_gr;

    assign pix_ready = (state == ACCEPT);
    assign busy      = (state == ACCEPT) || (state == WR_B) || (state == WR_G) || (state == WR_R);
    assign DEC_DONE  = (state == DONE);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            x         <= '0;
            y         <= '0;
            row_base  <= '0;
            col_off   <= '0;
            pix_gr    <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // abort beats a simultaneous start and drops a completed frame's status
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        state    <= ACCEPT;
                        x        <= '0;
                        y        <= '0;
                        row_base <= TOP_BASE;
                        col_off  <= '0;
                    end
                end
                ACCEPT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (pix_valid) begin
                        state     <= WR_B;
                        pix_gr    <= pix_data[23:8];
                        mem_we    <= 1'b1;
                        mem_addr  <= row_base + col_off;
                        mem_wdata <= pix_data[7:0];
                    end
                end
                WR_B: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state     <= WR_G;
                        mem_we    <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= pix_gr[7:0];
                    end
                end
                WR_G: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state     <= WR_R;
                        mem_we    <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= pix_gr[15:8];
                    end
                end
                WR_R: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (x == X_LAST && y == Y_LAST) begin
                        state <= DONE;
                    end else begin
                        state <= ACCEPT;
                        // rows walk downwards in memory: BMP stores the bottom row first
                        if (x == X_LAST) begin
                            x        <= '0;
                            col_off  <= '0;
                            y        <= y + 1'b1;
                            row_base <= row_base - ROW_BYTES;
                        end else begin
                            x       <= x + 1'b1;
                            col_off <= col_off + ADDR_W'(3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_frame_ctrl.sv
// Scoreboard bench for display_frame_ctrl at 4x2: expected byte writes are queued as pixels are offered.
module tb_display_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } exp_t;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic [23:0]   pix_data = '0;
    logic          pix_ready, mem_we, busy, DEC_DONE;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    int   vectors = 0;
    int   miscompares = 0;
    int   writes = 0;
    exp_t sb[$];

    display_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .DEC_DONE(DEC_DONE)
    );

    always #5 HCLK = ~HCLK;

    // Write monitor: every strobe must match the oldest outstanding expectation
    always @(negedge HCLK) begin
        if (mem_we === 1'b1) begin
            exp_t e;
            writes++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%0d data=%02h, no write expected", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL write addr/data got (%0d,%02h) expected (%0d,%02h)", mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [AW-1:0] pix_addr(input int p);
        return AW'((H - 1 - p / W) * W * 3 + (p % W) * 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", name, got, exp_v);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (pix_ready !== 1'b1 && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (pix_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout got pix_ready=%b expected 1 within 50 cycles", pix_ready);
        end
    endtask

    // Offers one pixel at pixel index p; queues the first nbytes of its B,G,R writes.
    // Returns at the negedge inside WR_B.
    task automatic accept_pixel(input logic [23:0] d, input int p, input int nbytes);
        logic [AW-1:0] a;
        wait_ready();
        a = pix_addr(p);
        if (nbytes > 0) sb.push_back('{a: a,            d: d[7:0]});
        if (nbytes > 1) sb.push_back('{a: a + AW'(1),  d: d[15:8]});
        if (nbytes > 2) sb.push_back('{a: a + AW'(2),  d: d[23:16]});
        pix_valid = 1'b1;
        pix_data  = d;
        @(negedge HCLK);
        pix_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
        chk({tag, "_mem_we"},    32'(mem_we),    0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_dec_done"},  32'(DEC_DONE),  0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    endtask

    // Full frame with random gaps of 0..gap_max idle cycles before each pixel
    task automatic run_frame(input int gap_max);
        int w0 = writes;
        pulse_start();
        for (int p = 0; p < W * H; p++) begin
            int gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            wait_ready();
            for (int g = 0; g < gap; g++) begin
                chk("gap_mem_we", 32'(mem_we), 0);
                @(negedge HCLK);
            end
            accept_pixel(24'($urandom), p, 3);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("frame_dec_done",  32'(DEC_DONE),  1);
        chk("frame_busy",      32'(busy),      0);
        chk("frame_pix_ready", 32'(pix_ready), 0);
        chk("frame_mem_we",    32'(mem_we),    0);
        chk("frame_write_cnt", 32'(writes - w0), 32'(W * H * 3));
        chk("frame_sb_empty",  32'(sb.size()), 0);
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        do_reset();
        check_all_zero("reset");
    endtask

    task automatic test_first_pixel();
        pulse_start();
        chk("start_pix_ready", 32'(pix_ready), 1);
        accept_pixel(24'h112233, 0, 3);
        chk("wr_b_we", 32'(mem_we), 1);
        @(negedge HCLK);
        chk("wr_g_we", 32'(mem_we), 1);
        @(negedge HCLK);
        chk("wr_r_we", 32'(mem_we), 1);
        @(negedge HCLK);
        chk("after_pix_ready", 32'(pix_ready), 1);
        chk("after_hold_addr", 32'(mem_addr), 14);
        chk("after_sb_empty", 32'(sb.size()), 0);
        do_reset();
    endtask

    task automatic test_back_to_back();
        run_frame(0);
        repeat (5) @(negedge HCLK);
        chk("done_held", 32'(DEC_DONE), 1);
        // restart from DONE clears the flag on the same edge
        pulse_start();
        chk("restart_dec_done", 32'(DEC_DONE), 0);
        chk("restart_busy", 32'(busy), 1);
        do_reset();
    endtask

    task automatic test_gaps();
        run_frame(5);
        // abort together with start in DONE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_dec_done", 32'(DEC_DONE), 0);
        chk("abort_start_ready", 32'(pix_ready), 0);
        do_reset();
    endtask

    task automatic test_start_abort();
        pulse_start();
        accept_pixel(24'($urandom), 0, 3);
        accept_pixel(24'hA1B2C3, 1, 3);
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        chk("start_ignored_busy", 32'(busy), 1);
        accept_pixel(24'($urandom), 2, 3);
        accept_pixel(24'h445566, 3, 1);
        abort = 1'b1;
        @(negedge HCLK);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dec_done", 32'(DEC_DONE), 0);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_sb_empty", 32'(sb.size()), 0);
        pulse_start();
        accept_pixel(24'h112233, 0, 3);
        repeat (3) @(negedge HCLK);
        chk("restart_sb_empty", 32'(sb.size()), 0);
        do_reset();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        accept_pixel(24'h778899, 0, 2);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_all_zero("rst_mid");
        chk("rst_mid_sb_empty", 32'(sb.size()), 0);
        run_frame(1);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_all_zero("rst_done");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired, bench did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_back_to_back();
        test_gaps();
        test_start_abort();
        test_reset_mid();
        repeat (3) @(negedge HCLK);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/display_frame_ctrl.md
DISPLAY_FRAME_CTRL -- requirements
Module: display_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 240, image width in pixels.
REQ-002 Parameter HEIGHT, default 320, image height in pixels.
REQ-003 Parameter ADDR_W, default 18, frame-buffer byte address width; SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT*3.
REQ-004 HCLK  input  1  sole clock; all state changes on rising edge.
REQ-005 HRESET  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 abort  input  1  abandon current frame.
REQ-008 pix_valid  input  1  source pixel valid.
REQ-009 pix_data  input  24  source pixel: R[23:16], G[15:8], B[7:0].
REQ-010 pix_ready  output  1  block accepts pixel this cycle.
REQ-011 mem_we  output  1  frame-buffer byte write strobe.
REQ-012 mem_addr  output  ADDR_W  frame-buffer byte address.
REQ-013 mem_wdata  output  8  frame-buffer byte data.
REQ-014 busy  output  1  frame in progress.
REQ-015 DEC_DONE  output  1  complete frame stored, buffer ready for BMP dump.

Function
REQ-016 States: IDLE, ACCEPT, WR_B, WR_G, WR_R, DONE; all outputs decoded from registered state/counters, no input-to-output combinational path except none (pix_ready = state==ACCEPT).
REQ-017 IDLE or DONE: start=1 -> ACCEPT next cycle; x=0, y=0, row_base=(HEIGHT-1)*WIDTH*3, col_off=0, DEC_DONE cleared same edge.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 ACCEPT: pix_ready=1; pix_valid=1 -> pixel captured, next state WR_B; pix_valid=0 -> remain, no write.
REQ-020 Pixels arrive raster order: top row first, left to right.
REQ-021 WR_B/WR_G/WR_R: mem_we=1 one cycle each, mem_addr=row_base+col_off+0/1/2, mem_wdata=B/G/R of captured pixel respectively.
REQ-022 Storage order SHALL be BMP bottom-up: source row y lands at byte base (HEIGHT-1-y)*WIDTH*3; no row padding (WIDTH*3 multiple of 4 assumed by parameter choice; non-multiples unsupported).
REQ-023 Address generation incremental, no multipliers: col_off += 3 per pixel; at x==WIDTH-1, x->0, col_off->0, y+=1, row_base -= WIDTH*3.
REQ-024 Leaving WR_R: if x==WIDTH-1 and y==HEIGHT-1 -> DONE, else ACCEPT; throughput one pixel per 4 cycles max.
REQ-025 DONE: DEC_DONE=1, busy=0, pix_ready=0, mem_we=0; held until start or reset.
REQ-026 busy=1 in ACCEPT, WR_B, WR_G, WR_R only.
REQ-027 abort=1 in any busy state -> IDLE next cycle; an in-flight byte write that cycle still completes, remaining bytes of that pixel dropped; DEC_DONE stays 0.
REQ-028 abort and start same cycle in IDLE/DONE: abort wins, state IDLE, DEC_DONE cleared.
REQ-029 Outside WR_* states mem_we=0, mem_addr and mem_wdata hold previous values.
REQ-030 Counters: x width clog2(WIDTH), y width clog2(HEIGHT); no wrap past HEIGHT-1.

Reset
REQ-031 HRESET=1 at an edge -> state IDLE; pix_ready, mem_we, busy, DEC_DONE = 0; mem_addr, mem_wdata = 0; x, y, col_off, row_base = 0.
REQ-032 Reset overrides start and abort; reset mid-frame discards frame, no further writes.

Verification (WIDTH=4, HEIGHT=2 unless stated)
REQ-033 Reset, start, pixel 0x112233 -> writes (12,0x33),(13,0x22),(14,0x11) on 3 consecutive cycles, then pix_ready=1.
REQ-034 Stream 8 pixels back-to-back -> 24 writes, last pixel to addresses 9,10,11, DEC_DONE=1 cycle after final WR_R, busy=0.
REQ-035 pix_valid gaps of 0-5 cycles -> identical address/data sequence, no writes during gaps.
REQ-036 start asserted during WR_G -> ignored; abort during pixel 3 -> IDLE next cycle, DEC_DONE=0, subsequent start restarts at address 12.
REQ-037 Defaults 240x320: full frame -> first byte address 229680, last byte address 719, DEC_DONE=1, exactly 230400 writes; byte image matches reference BMP pixel array.
REQ-038 HRESET asserted mid-frame and in DONE -> all outputs 0 next cycle, DEC_DONE cleared.
